// File: rtl/lpc_reg_pkg.sv
// Shared types and constants for the LPC register-file arbiter.
// Lock key/address constants are used only when LPC_REG_WRLOCK_EN is defined.
package lpc_reg_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   localparam int         REG_DEPTH_DEF = 32;
   localparam logic [7:0] KEY_UNLOCK    = 8'hA5;
   localparam logic [7:0] KEY_LOCK      = 8'h5A;
   localparam logic [7:0] LOCK_ADDR     = 8'h20;

endpackage

// File: rtl/lpc_reg_arbiter_if.sv
// Requester/register-file bundle around lpc_reg_arbiter.
// slave = arbiter side, master = requesters plus register file.
interface lpc_reg_arbiter_if #(
   parameter int NUM_REQ = 3
) ();

   logic [NUM_REQ-1:0]   ReqVec;
   logic [NUM_REQ-1:0]   ReqWr;
   logic [NUM_REQ*8-1:0] ReqAddr;
   logic [NUM_REQ*8-1:0] ReqData;
   logic [NUM_REQ-1:0]   GntVec;
   logic [NUM_REQ-1:0]   AckVec;
   logic [7:0]           RdData;
   logic                 ErrFlag;
   logic                 Busy;
   logic [7:0]           RegAddr;
   logic                 RegWr;
   logic [7:0]           RegDataWr;
   logic [7:0]           RegDataRd;

   modport slave (
      input  ReqVec, ReqWr, ReqAddr, ReqData, RegDataRd,
      output GntVec, AckVec, RdData, ErrFlag, Busy,
      output RegAddr, RegWr, RegDataWr
   );

   modport master (
      output ReqVec, ReqWr, ReqAddr, ReqData, RegDataRd,
      input  GntVec, AckVec, RdData, ErrFlag, Busy,
      input  RegAddr, RegWr, RegDataWr
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above
// i_ptr, wrapping, as a one-hot grant plus its index.
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [IW:0] w_sum;
   logic        w_found;

   always_comb begin
      w_sum   = '0;
      w_found = 1'b0;
      o_idx   = '0;
      o_gnt   = '0;
      for (int k = 0; k < N; k++) begin
         w_sum = {1'b0, i_ptr} + (IW+1)'(k);
         if (w_sum >= (IW+1)'(N))
            w_sum = w_sum - (IW+1)'(N);
         if (!w_found && i_req[w_sum[IW-1:0]]) begin
            w_found = 1'b1;
            o_idx   = w_sum[IW-1:0];
         end
      end
      if (w_found)
         o_gnt = N'(1) << o_idx;
      o_any = w_found;
   end

endmodule

// File: rtl/lpc_reg_arbiter.sv
// Round-robin arbiter for the single LPC register-file port.
// Optional write lock enabled by defining LPC_REG_WRLOCK_EN.
module lpc_reg_arbiter
   import lpc_reg_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int REG_DEPTH = REG_DEPTH_DEF
) (
   input  logic              LpcClock,
   input  logic              PciReset,
   lpc_reg_arbiter_if.slave  bus
);

   localparam int IW = $clog2(NUM_REQ);

   state_t             r_state;
   state_t             w_next;
   logic [IW-1:0]      r_ptr;
   logic [IW-1:0]      r_idx;
   logic [NUM_REQ-1:0] r_gnt;
   logic [7:0]         r_addr;
   logic [7:0]         r_data;
   logic [7:0]         r_rd;
   logic               r_wren;
   logic               r_err;
   logic               r_zero;

   logic [NUM_REQ-1:0] w_pgnt;
   logic [IW-1:0]      w_pidx;
   logic               w_pany;
   logic               w_wr;
   logic [7:0]         w_addr;
   logic [7:0]         w_data;
   logic               w_inr;
   logic               w_wren;
   logic               w_err;
   logic               w_zero;
   logic               w_load;
   logic               w_done;
   logic [7:0]         w_rd;
   logic [IW-1:0]      w_ptr_nxt;

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .i_req (bus.ReqVec),
      .i_ptr (r_ptr),
      .o_gnt (w_pgnt),
      .o_idx (w_pidx),
      .o_any (w_pany)
   );

   always_comb begin
      w_wr   = bus.ReqWr[w_pidx];
      w_addr = bus.ReqAddr[{w_pidx, 3'b000} +: 8];
      w_data = bus.ReqData[{w_pidx, 3'b000} +: 8];
      w_inr  = (int'(w_addr) < REG_DEPTH);
      w_zero = !w_inr;
   end

`ifdef LPC_REG_WRLOCK_EN
   logic r_lock;
   logic r_key;
   logic w_key;
   logic w_lkd;

   // Key writes to the lock address are accepted even though out of range.
   always_comb begin
      w_key  = w_wr && (w_addr == LOCK_ADDR) &&
               ((w_data == KEY_UNLOCK) || (w_data == KEY_LOCK));
      w_lkd  = r_lock && w_wr && w_inr && (w_addr != 8'h00);
      w_wren = w_wr && w_inr && !w_lkd;
      w_err  = (!w_inr && !w_key) || w_lkd;
   end

   always_ff @(posedge LpcClock) begin
      if (PciReset) begin
         r_lock <= 1'b1;
         r_key  <= 1'b0;
      end else begin
         if (w_load)
            r_key <= w_key;
         if (w_done && r_key)
            r_lock <= (r_data == KEY_LOCK);
      end
   end
`else
   always_comb begin
      w_wren = w_wr && w_inr;
      w_err  = !w_inr;
   end
`endif

   always_ff @(posedge LpcClock) begin
      if (PciReset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_done = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_pany) begin
               w_next = ISSUE;
               w_load = 1'b1;
            end
         end
         ISSUE:   w_next = CAPTURE;
         CAPTURE: begin
            w_next = IDLE;
            w_done = 1'b1;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_ptr_nxt = (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + IW'(1);
   assign w_rd      = r_zero ? 8'h00 : bus.RegDataRd;

   always_ff @(posedge LpcClock) begin
      if (PciReset) begin
         r_ptr  <= '0;
         r_idx  <= '0;
         r_gnt  <= '0;
         r_addr <= '0;
         r_data <= '0;
         r_rd   <= '0;
         r_wren <= 1'b0;
         r_err  <= 1'b0;
         r_zero <= 1'b0;
      end else begin
         if (w_load) begin
            r_idx  <= w_pidx;
            r_gnt  <= w_pgnt;
            r_addr <= w_addr;
            r_data <= w_data;
            r_wren <= w_wren;
            r_err  <= w_err;
            r_zero <= w_zero;
         end
         if (w_done) begin
            r_gnt <= '0;
            r_rd  <= w_rd;
            r_ptr <= w_ptr_nxt;
         end
      end
   end

   // RdData passes the post-write byte through during CAPTURE, then holds it.
   assign bus.GntVec    = r_gnt;
   assign bus.AckVec    = (r_state == CAPTURE && !PciReset) ? r_gnt : '0;
   assign bus.RdData    = (r_state == CAPTURE) ? w_rd : r_rd;
   assign bus.ErrFlag   = (r_state == CAPTURE) && !PciReset && r_err;
   assign bus.Busy      = (r_state != IDLE);
   assign bus.RegAddr   = r_addr;
   assign bus.RegDataWr = r_data;
   assign bus.RegWr     = (r_state == ISSUE) && r_wren && !PciReset;

endmodule

// File: tb/tb_lpc_reg_arbiter.sv
// Bench for lpc_reg_arbiter: transaction-schedule model plus directed checks.
// Lock expectations follow LPC_REG_WRLOCK_EN.
module tb_lpc_reg_arbiter;
   import lpc_reg_pkg::*;

   localparam int N = 3;
`ifdef LPC_REG_WRLOCK_EN
   localparam bit LK = 1'b1;
`else
   localparam bit LK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lpc_reg_arbiter_if #(.NUM_REQ(N)) bus ();

   lpc_reg_arbiter #(.NUM_REQ(N), .REG_DEPTH(32)) dut (
      .LpcClock (clk),
      .PciReset (rst),
      .bus      (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [N-1:0] rq_v = '0;
   logic [N-1:0] rq_w = '0;
   logic [7:0]   rq_a [N];
   logic [7:0]   rq_d [N];

   assign bus.ReqVec  = rq_v;
   assign bus.ReqWr   = rq_w;
   assign bus.ReqAddr = {rq_a[2], rq_a[1], rq_a[0]};
   assign bus.ReqData = {rq_d[2], rq_d[1], rq_d[0]};

   function automatic logic [7:0] wmask(input logic [7:0] a);
      return (a == 8'h1F) ? 8'h0F : 8'hFF;
   endfunction

   // Register file stand-in: address 0x1F keeps only its low nibble.
   logic [7:0] rf [32];
   assign bus.RegDataRd = (bus.RegAddr < 8'd32) ? rf[bus.RegAddr[4:0]] : 8'hEE;
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++)
            rf[5'(i)] <= (i == 16) ? 8'h9C : 8'h00;
      end else if (bus.RegWr && bus.RegAddr < 8'd32) begin
         rf[bus.RegAddr[4:0]] <= bus.RegDataWr & wmask(bus.RegAddr);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
      end
   endtask

   typedef struct {
      bit           v;
      logic [N-1:0] gnt;
      logic [N-1:0] ack;
      logic         regwr;
      logic [7:0]   addr;
      logic [7:0]   dwr;
      logic [7:0]   rd;
      logic         err;
      logic         busy;
   } exp_t;

   exp_t       ring [4];
   exp_t       e;
   logic [7:0] mm [32];
   int         m_ptr, m_nfree, m_w;
   bit         m_found, m_lock;
   logic [N-1:0] m_rv;
   logic [1:0] m_wi;
   logic [7:0] m_la, m_ld, m_lr, m_a, m_d, m_rd;
   bit         m_wr, m_inr, m_key, m_lkd, m_dowr, m_err;

   // Each accepted request books its ISSUE and CAPTURE cycles ahead.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         m_ptr = 0; m_nfree = 0; m_lock = 1'b1;
         m_la = '0; m_ld = '0; m_lr = '0;
         for (int i = 0; i < 4; i++) ring[i].v = 1'b0;
         for (int i = 0; i < 32; i++) mm[5'(i)] = (i == 16) ? 8'h9C : 8'h00;
      end else begin
         if (ring[2'(cyc)].v) e = ring[2'(cyc)];
         else begin
            e.gnt = '0; e.ack = '0; e.regwr = 1'b0; e.err = 1'b0;
            e.busy = 1'b0; e.addr = m_la; e.dwr = m_ld; e.rd = m_lr;
         end
         ring[2'(cyc)].v = 1'b0;
         chk("m_gnt", bus.GntVec, e.gnt);
         chk("m_ack", bus.AckVec, e.ack);
         chk("m_regwr", bus.RegWr, e.regwr);
         chk("m_regaddr", bus.RegAddr, e.addr);
         chk("m_regdatawr", bus.RegDataWr, e.dwr);
         chk("m_rddata", bus.RdData, e.rd);
         chk("m_err", bus.ErrFlag, e.err);
         chk("m_busy", bus.Busy, e.busy);
         if (cyc >= m_nfree && |rq_v) begin
            m_found = 1'b0; m_w = 0;
            for (int k = 0; k < N; k++) begin
               m_rv = rq_v >> ((m_ptr + k) % N);
               if (!m_found && m_rv[0]) begin
                  m_found = 1'b1;
                  m_w = (m_ptr + k) % N;
               end
            end
            m_wi  = 2'(m_w);
            m_wr  = rq_w[m_wi];
            m_a   = rq_a[m_wi];
            m_d   = rq_d[m_wi];
            m_inr = (m_a < 8'd32);
            m_key = LK && m_wr && m_a == 8'h20 && (m_d == 8'hA5 || m_d == 8'h5A);
            m_lkd = LK && m_lock && m_wr && m_inr && m_a != 8'h00;
            m_dowr = m_wr && m_inr && !m_lkd;
            m_err = (!m_inr && !m_key) || m_lkd;
            if (!m_inr) m_rd = 8'h00;
            else begin
               if (m_dowr) mm[m_a[4:0]] = m_d & wmask(m_a);
               m_rd = mm[m_a[4:0]];
            end
            if (m_key) m_lock = (m_d == 8'h5A);
            ring[2'(cyc + 1)] = '{1'b1, N'(1) << m_w, '0, m_dowr, m_a, m_d,
                                  m_lr, 1'b0, 1'b1};
            ring[2'(cyc + 2)] = '{1'b1, N'(1) << m_w, N'(1) << m_w, 1'b0,
                                  m_a, m_d, m_rd, m_err, 1'b1};
            m_la = m_a; m_ld = m_d; m_lr = m_rd;
            m_ptr = (m_w + 1) % N;
            m_nfree = cyc + 3;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input logic [1:0] r, input bit w, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] x_rd,
                      input bit x_err, input bit x_wr);
      int t;
      bit got;
      rq_w[r] = w; rq_a[r] = a; rq_d[r] = d; rq_v[r] = 1'b1;
      got = 1'b0;
      for (t = 0; t < 8; t++) begin
         @(negedge clk);
         if (t == 1) chk("t_regwr", bus.RegWr, x_wr);
         if (bus.AckVec[r]) begin
            got = 1'b1;
            break;
         end
      end
      chk("t_ack_seen", got, 1);
      if (got) begin
         chk("t_ack_lat", t, 2);
         chk("t_rddata", bus.RdData, x_rd);
         chk("t_err", bus.ErrFlag, x_err);
      end
      tick();
      rq_v[r] = 1'b0;
   endtask

   int ord[$];
   int acy[$];
   bit got2;

   initial begin
      for (int i = 0; i < N; i++) begin
         rq_a[i] = '0;
         rq_d[i] = '0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_gnt", bus.GntVec, 0);
      chk("rst_busy", bus.Busy, 0);
      chk("rst_rddata", bus.RdData, 0);
      chk("rst_regaddr", bus.RegAddr, 0);
      tick();

`ifdef LPC_REG_WRLOCK_EN
      txn(2'd0, 1, 8'h02, 8'h11, 8'h00, 1, 0);
      txn(2'd1, 1, 8'h20, 8'hA5, 8'h00, 0, 0);
      txn(2'd0, 1, 8'h02, 8'h11, 8'h11, 0, 1);
`else
      txn(2'd1, 1, 8'h20, 8'hA5, 8'h00, 1, 0);
`endif
      txn(2'd0, 0, 8'h0F, 8'h00, 8'h00, 0, 0);
      txn(2'd1, 1, 8'h05, 8'h3C, 8'h3C, 0, 1);
      txn(2'd2, 0, 8'h05, 8'h00, 8'h3C, 0, 0);
      txn(2'd0, 0, 8'h40, 8'h00, 8'h00, 1, 0);
      txn(2'd1, 0, 8'h10, 8'h00, 8'h9C, 0, 0);
      txn(2'd2, 1, 8'h1F, 8'hAB, 8'h0B, 0, 1);
      txn(2'd0, 0, 8'h20, 8'h00, 8'h00, 1, 0);
      txn(2'd1, 1, 8'hFF, 8'h12, 8'h00, 1, 0);
`ifdef LPC_REG_WRLOCK_EN
      txn(2'd2, 1, 8'h20, 8'h5A, 8'h00, 0, 0);
      txn(2'd0, 1, 8'h00, 8'h77, 8'h77, 0, 1);
      txn(2'd1, 1, 8'h05, 8'h99, 8'h3C, 1, 0);
`endif

      // All three requesters held across reset.
      rq_w = 3'b010;
      rq_a[0] = 8'h10; rq_a[1] = 8'h07; rq_a[2] = 8'h07;
      rq_d[1] = 8'h55;
      rq_v = 3'b111;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      for (int t = 0; t < 40 && ord.size() < 6; t++) begin
         @(negedge clk);
         for (int k = 0; k < N; k++)
            if (bus.AckVec[k]) begin
               ord.push_back(k);
               acy.push_back(cyc);
            end
      end
      tick();
      rq_v = '0;
      chk("rr_ack_count", ord.size(), 6);
      for (int i = 0; i < ord.size(); i++)
         chk("rr_order", ord[i], i % N);
      for (int i = 1; i < acy.size(); i++)
         chk("rr_ack_gap", acy[i] - acy[i-1], 3);

      // Reset during ISSUE, after a grant to requester 0 moved the pointer.
      txn(2'd0, 0, 8'h0F, 8'h00, 8'h00, 0, 0);
      rq_w[1] = 1'b1; rq_a[1] = 8'h06; rq_d[1] = 8'h77; rq_v[1] = 1'b1;
      @(negedge clk);
      tick();
      rst = 1'b1;
      rq_v = '0;
      @(negedge clk);
      chk("mid_rst_regwr", bus.RegWr, 0);
      chk("mid_rst_ack", bus.AckVec, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_gnt", bus.GntVec, 0);
      chk("post_rst_ack", bus.AckVec, 0);
      chk("post_rst_busy", bus.Busy, 0);
      chk("post_rst_regaddr", bus.RegAddr, 0);
      chk("post_rst_regdatawr", bus.RegDataWr, 0);
      chk("post_rst_rddata", bus.RdData, 0);
      tick();

      rq_w = '0; rq_a[0] = 8'h01; rq_a[2] = 8'h02;
      rq_v = 3'b101;
      got2 = 1'b0;
      for (int t = 0; t < 8 && !got2; t++) begin
         @(negedge clk);
         if (|bus.AckVec) begin
            got2 = 1'b1;
            chk("ptr_reset_winner", bus.AckVec, 3'b001);
         end
      end
      chk("ptr_first_ack_seen", got2, 1);
      tick();
      rq_v[0] = 1'b0;
      got2 = 1'b0;
      for (int t = 0; t < 8 && !got2; t++) begin
         @(negedge clk);
         if (|bus.AckVec) begin
            got2 = 1'b1;
            chk("ptr_second_winner", bus.AckVec, 3'b100);
         end
      end
      chk("ptr_second_ack_seen", got2, 1);
      tick();
      rq_v = '0;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lpc_reg_arbiter.md
Name: lpc_reg_arbiter

Overview:
Shares the single write/read port of the 32-byte LPC register file between NUM_REQ requesters: the LPC host cycle decoder, the BMC/I2C side and internal hardware sequencers. Round-robin arbitration with a 3-state access FSM. Each transaction drives one register access (address, write strobe, write data), captures the resulting register byte and acknowledges the winner. Sits between the requesters and the register file inside the Lpc hierarchy.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
REG_DEPTH, 32, number of valid register addresses (0x00..REG_DEPTH-1)

Ports:
LpcClock  in  1  33 MHz LPC clock; sole clock
PciReset  in  1  reset, synchronous, active-high
ReqVec  in  NUM_REQ  per-requester request level
ReqWr  in  NUM_REQ  per-requester 1=write, 0=read
ReqAddr  in  NUM_REQ*8  per-requester address, requester i at [8i+7:8i]
ReqData  in  NUM_REQ*8  per-requester write data, same packing
GntVec  out  NUM_REQ  one-hot grant, high ISSUE through CAPTURE
AckVec  out  NUM_REQ  one-hot, one-cycle completion pulse
RdData  out  8  captured register byte, valid with Ack, held until next capture
ErrFlag  out  1  high with Ack if the address was out of range (or locked)
Busy  out  1  high whenever FSM is not IDLE
RegAddr  out  8  register file address
RegWr  out  1  register file write strobe, one cycle
RegDataWr  out  8  register file write data
RegDataRd  in  8  register byte at RegAddr (combinational mux outside this block)

Behaviour:
- Interface: one clock (LpcClock); reset PciReset is synchronous and active-high.
- Reset: state IDLE, RR pointer 0, GntVec/AckVec/RdData/RegAddr/RegDataWr = 0, RegWr/ErrFlag/Busy = 0. Reset mid-transaction aborts it: no Ack, no RegWr.
- FSM IDLE -> ISSUE -> CAPTURE -> IDLE; no back-to-back bypass.
- IDLE: if any ReqVec bit set, pick the first set bit searching from pointer upward with wrap. Latch its Wr/Addr/Data, set GntVec, go ISSUE. Otherwise stay.
- ISSUE (1 cycle): RegAddr/RegDataWr drive latched values. RegWr = latched Wr AND addr < REG_DEPTH. Go CAPTURE.
- CAPTURE (1 cycle): RegAddr held. RdData <= RegDataRd; for writes this is the post-write masked value. AckVec pulses for the winner. ErrFlag = (addr >= REG_DEPTH); on error RdData <= 0x00. Pointer <= winner+1 mod NUM_REQ. GntVec clears on exit.
- Latency: Req sampled in IDLE cycle n, RegWr at n+1, Ack at n+2. Peak rate is one access every 3 cycles.
- Requester must hold Req/Wr/Addr/Data until Ack. A Req still high in the first IDLE cycle after Ack counts as a new request.
- Dropping Req mid-transaction does not abort; Ack is still issued.
- Simultaneous requests: strict RR, so each of NUM_REQ persistent requesters is served once per NUM_REQ transactions.
- Addresses 0x00..REG_DEPTH-1 use the full 8-bit compare; 0x20..0xFF are errors.

Optional Feature:
LPC_REG_WRLOCK_EN
- With macro: a 1-bit lock register, reset 1 (locked).
- A write of 0xA5 to address REG_DEPTH (0x20) clears the lock; a write of 0x5A there sets it. Either is acked, ErrFlag=0, no RegWr.
- While locked, writes to 0x01..REG_DEPTH-1 complete with ErrFlag=1 and no RegWr, and RdData returns the current register value. Reads are unaffected.
- Without macro: no lock, and address 0x20 is an ordinary out-of-range error.

Decomposition:
- Package lpc_reg_pkg: FSM state enum (IDLE, ISSUE, CAPTURE), REG_DEPTH default, unlock/lock key constants 0xA5/0x5A, lock address 0x20.
- One natural sub-module: rr_pick, a combinational round-robin priority picker (request vector + pointer -> one-hot grant + index), reusable by other arbiters.

Test Plan:
- Single read: requester 0 reads 0x0F after reset, RegDataRd=0x00 -> Gnt[0] at n+1; Ack[0] at n+2; RdData=0x00; ErrFlag=0; RegWr never high.
- Single write: requester 1 writes 0x3C to 0x05 -> RegWr=1 with RegAddr=0x05, RegDataWr=0x3C at n+1; Ack[1] at n+2; RdData=0x3C.
- Contention: all 3 requesters hold Req from reset -> grant order 0,1,2,0,1,2, acks spaced exactly 3 cycles apart.
- Out of range: read 0x40 -> Ack with ErrFlag=1, RdData=0x00, no RegWr.
- Reset mid-op: PciReset asserted during ISSUE -> no Ack; all outputs 0 next cycle; pointer back to 0.
- WRLOCK_EN: write 0x11 to 0x02 while locked -> ErrFlag=1, no RegWr. Write 0xA5 to 0x20, then 0x11 to 0x02 -> RegWr pulses, ErrFlag=0.
